// File: rtl/nios2_oci_dct_sequencer.sv
// Packs 2-bit Nios II OCI trace atoms into 30-bit frames and sequences the end-of-test drain.
// Optional idle-timeout partial flush is enabled by defining DCT_TIMEOUT_FLUSH_EN.
module nios2_oci_dct_sequencer #(
  parameter int ATOM_W  = 2,
  parameter int SLOTS   = 15,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    atom_valid_i,
  input  logic [ATOM_W-1:0]       atom_data_i,
  output logic                    atom_ready_o,
  output logic                    frame_valid_o,
  output logic [ATOM_W*SLOTS-1:0] frame_data_o,
  output logic [CNT_W-1:0]        frame_count_o,
  input  logic                    frame_ready_i,
  output logic [ATOM_W*SLOTS-1:0] dct_buffer_o,
  output logic [CNT_W-1:0]        dct_count_o,
  input  logic                    test_ending_i,
  output logic                    test_has_ended_o
);

  localparam int BUF_W = ATOM_W * SLOTS;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SLOTS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(SLOTS);

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_FLUSH      = 2'd1,
    S_WAIT_EMPTY = 2'd2,
    S_ENDED      = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fv_q, fv_d;
  logic [BUF_W-1:0]   fdata_q, fdata_d;
  logic [CNT_W-1:0]   fcnt_q, fcnt_d;

  logic               accept;
  logic [BUF_W-1:0]   buf_acc;
  logic               load;
  logic [BUF_W-1:0]   load_data;
  logic [CNT_W-1:0]   load_cnt;

`ifdef DCT_TIMEOUT_FLUSH_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic               tflush;
`endif

  // The last slot is blocked while the frame register is still occupied, so a full
  // buffer never has to overwrite a frame the FIFO has not taken yet.
  assign atom_ready_o = (state_q == S_RUN) && !((cnt_q == LAST_SLOT) && fv_q);
  assign accept       = atom_valid_i && atom_ready_o;
  assign buf_acc      = buf_q | ({{(BUF_W-ATOM_W){1'b0}}, atom_data_i} << (ATOM_W * int'(cnt_q)));

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    fv_d      = fv_q;
    fdata_d   = fdata_q;
    fcnt_d    = fcnt_q;
    load      = 1'b0;
    load_data = buf_q;
    load_cnt  = cnt_q;
`ifdef DCT_TIMEOUT_FLUSH_EN
    idle_d    = idle_q;
    tflush    = 1'b0;
`endif

    if (fv_q && frame_ready_i) fv_d = 1'b0;

    case (state_q)
      S_RUN: begin
        if (accept) begin
          if (cnt_q == LAST_SLOT) begin
            load      = 1'b1;
            load_data = buf_acc;
            load_cnt  = FULL_CNT;
            buf_d     = '0;
            cnt_d     = '0;
          end else begin
            buf_d = buf_acc;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef DCT_TIMEOUT_FLUSH_EN
        tflush = !accept && (idle_q == IDLE_MAX) && !fv_q && (cnt_q != '0);
        if (tflush) begin
          load  = 1'b1;
          buf_d = '0;
          cnt_d = '0;
        end
        // Counter saturates at TIMEOUT while a held frame blocks the partial flush.
        if (accept || tflush || test_ending_i) idle_d = '0;
        else if ((cnt_q != '0) && (idle_q != IDLE_MAX)) idle_d = idle_q + IDLE_W'(1);
`endif
        if (test_ending_i) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = S_WAIT_EMPTY;
        end else if (!fv_q) begin
          load    = 1'b1;
          buf_d   = '0;
          cnt_d   = '0;
          state_d = S_WAIT_EMPTY;
        end
      end
      S_WAIT_EMPTY: begin
        if (!fv_q) state_d = S_ENDED;
      end
      S_ENDED: ;
      default: state_d = S_RUN;
    endcase

    if (load) begin
      fv_d    = 1'b1;
      fdata_d = load_data;
      fcnt_d  = load_cnt;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_RUN;
      buf_q   <= '0;
      cnt_q   <= '0;
      fv_q    <= 1'b0;
      fdata_q <= '0;
      fcnt_q  <= '0;
`ifdef DCT_TIMEOUT_FLUSH_EN
      idle_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      fv_q    <= fv_d;
      fdata_q <= fdata_d;
      fcnt_q  <= fcnt_d;
`ifdef DCT_TIMEOUT_FLUSH_EN
      idle_q  <= idle_d;
`endif
    end
  end

  assign frame_valid_o    = fv_q;
  assign frame_data_o     = fdata_q;
  assign frame_count_o    = fcnt_q;
  assign dct_buffer_o     = buf_q;
  assign dct_count_o      = cnt_q;
  // Drain is reported as soon as the last frame has left, and stays set in ENDED.
  assign test_has_ended_o = (state_q == S_ENDED) || ((state_q == S_WAIT_EMPTY) && !fv_q);

endmodule

// File: tb/tb_nios2_oci_dct_sequencer.sv
// Scoreboard bench for nios2_oci_dct_sequencer: atom-list reference model, frame queue, negedge monitor.
module tb_nios2_oci_dct_sequencer;
  localparam int TO = 64;
  localparam int M_RUN = 0, M_FLUSH = 1, M_WAIT = 2, M_ENDED = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        atom_valid;
  logic [1:0]  atom_data;
  logic        atom_ready;
  logic        frame_valid;
  logic [29:0] frame_data;
  logic [3:0]  frame_count;
  logic        frame_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_ending;
  logic        test_has_ended;

  nios2_oci_dct_sequencer dut (
    .clk_i(clk), .reset_i(rst),
    .atom_valid_i(atom_valid), .atom_data_i(atom_data), .atom_ready_o(atom_ready),
    .frame_valid_o(frame_valid), .frame_data_o(frame_data), .frame_count_o(frame_count),
    .frame_ready_i(frame_ready), .dct_buffer_o(dct_buffer), .dct_count_o(dct_count),
    .test_ending_i(test_ending), .test_has_ended_o(test_has_ended)
  );

  always #5 clk = ~clk;

  typedef struct { logic [29:0] d; logic [3:0] c; } frm_t;
  frm_t expq[$];
  int   atoms[$];
  bit   mfv;
  int   mstate;
  int   idle;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [29:0] pack_atoms();
    logic [29:0] b = '0;
    foreach (atoms[i]) b = b | (30'(atoms[i]) << (2 * i));
    return b;
  endfunction

  function automatic bit exp_ready();
    return (mstate == M_RUN) && !(atoms.size() == 14 && mfv);
  endfunction

  function automatic bit exp_ended();
    return (mstate == M_ENDED) || (mstate == M_WAIT && !mfv);
  endfunction

  function automatic void model_reset();
    atoms.delete();
    expq.delete();
    mfv = 1'b0;
    mstate = M_RUN;
    idle = 0;
  endfunction

  function automatic void emit();
    frm_t f;
    f.d = pack_atoms();
    f.c = 4'(atoms.size());
    expq.push_back(f);
    atoms.delete();
    mfv = 1'b1;
  endfunction

  // One clock edge of the reference behaviour, given the inputs present at that edge.
  function automatic void model_step(input bit v, input int d, input bit te, input bit fr);
    bit ofv = mfv;
    bit acc = v && exp_ready();
    int osz = atoms.size();
    bit tf  = 1'b0;
    if (ofv && fr) mfv = 1'b0;
    case (mstate)
      M_RUN: begin
        if (acc) begin
          atoms.push_back(d);
          if (atoms.size() == 15) emit();
        end
`ifdef DCT_TIMEOUT_FLUSH_EN
        tf = !acc && idle == TO && !ofv && osz > 0;
        if (tf) emit();
        if (acc || tf || te) idle = 0;
        else if (osz > 0 && idle < TO) idle++;
`endif
        if (te) mstate = M_FLUSH;
      end
      M_FLUSH: begin
        if (osz == 0) mstate = M_WAIT;
        else if (!ofv) begin emit(); mstate = M_WAIT; end
      end
      M_WAIT: if (!ofv) mstate = M_ENDED;
      default: ;
    endcase
    if (tf) idle = 0;
  endfunction

  // Monitor: compares live state with the model and pops frames on each handshake.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_frame_valid", 32'(frame_valid), 0);
      chk("rst_frame_data", 32'(frame_data), 0);
      chk("rst_frame_count", 32'(frame_count), 0);
      chk("rst_dct_buffer", 32'(dct_buffer), 0);
      chk("rst_dct_count", 32'(dct_count), 0);
      chk("rst_test_has_ended", 32'(test_has_ended), 0);
    end else begin
      chk("dct_count", 32'(dct_count), 32'(atoms.size()));
      chk("dct_buffer", 32'(dct_buffer), 32'(pack_atoms()));
      chk("frame_valid", 32'(frame_valid), 32'(mfv));
      chk("atom_ready", 32'(atom_ready), 32'(exp_ready()));
      chk("test_has_ended", 32'(test_has_ended), 32'(exp_ended()));
      if (frame_valid) begin
        chk("frame_expected", 32'(expq.size() != 0), 1);
        if (expq.size() != 0) begin
          chk("frame_data", 32'(frame_data), 32'(expq[0].d));
          chk("frame_count", 32'(frame_count), 32'(expq[0].c));
          if (frame_ready) void'(expq.pop_front());
        end
      end
    end
  end

  // Advance one cycle: step the model for the edge just taken, drive new inputs, return at negedge.
  task automatic cyc(input bit v, input logic [1:0] d, input bit te, input bit fr);
    @(posedge clk);
    #1;
    if (!rst) model_step(atom_valid, int'(atom_data), test_ending, frame_ready);
    atom_valid  = v;
    atom_data   = d;
    test_ending = te;
    frame_ready = fr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    atom_valid = 1'b0; atom_data = 2'b00; test_ending = 1'b0; frame_ready = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bit seen;
    int pv, pr;
    rst = 1'b1;
    atom_valid = 1'b0; atom_data = 2'b00; test_ending = 1'b0; frame_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);

    // Full frame of 2'b01 with FIFO ready.
    repeat (15) cyc(1'b1, 2'b01, 1'b0, 1'b1);
    cyc(1'b0, 2'b00, 1'b0, 1'b1);
    chk("t2_frame_valid", 32'(frame_valid), 1);
    chk("t2_frame_data", 32'(frame_data), 32'h15555555);
    chk("t2_frame_count", 32'(frame_count), 15);
    chk("t2_dct_count", 32'(dct_count), 0);
    repeat (2) cyc(1'b0, 2'b00, 1'b0, 1'b1);

    // Back-pressure: 29 atoms with the FIFO stalled.
    do_reset();
    for (int i = 0; i < 29; i++) cyc(1'b1, 2'($urandom), 1'b0, 1'b0);
    cyc(1'b1, 2'($urandom), 1'b0, 1'b0);
    chk("t3_dct_count", 32'(dct_count), 14);
    chk("t3_atom_ready", 32'(atom_ready), 0);
    chk("t3_frame_valid", 32'(frame_valid), 1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 2'b00, 1'b0, 1'b1);

    // Mid-stream reset with a held frame and 7 buffered atoms.
    do_reset();
    for (int i = 0; i < 22; i++) cyc(1'b1, 2'($urandom), 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b0);
    chk("t1_pre_dct_count", 32'(dct_count), 7);
    do_reset();
    chk("t1_atom_ready", 32'(atom_ready), 1);

    // Partial flush of 5 x 2'b11 on test_ending.
    do_reset();
    repeat (5) cyc(1'b1, 2'b11, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 8 && !frame_valid; i++) cyc(1'b0, 2'b00, 1'b0, 1'b0);
    chk("t4_frame_valid", 32'(frame_valid), 1);
    chk("t4_frame_data", 32'(frame_data), 32'h000003FF);
    chk("t4_frame_count", 32'(frame_count), 5);
    chk("t4_ended_before", 32'(test_has_ended), 0);
    cyc(1'b0, 2'b00, 1'b0, 1'b1);
    cyc(1'b0, 2'b00, 1'b0, 1'b1);
    chk("t4_ended", 32'(test_has_ended), 1);
    repeat (3) cyc(1'b1, 2'b01, 1'b0, 1'b1);
    chk("t4_ended_sticky", 32'(test_has_ended), 1);

    // Empty drain: ends quickly with no frame.
    do_reset();
    cyc(1'b0, 2'b00, 1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 2'b00, 1'b0, 1'b0);
      if (frame_valid) seen = 1'b1;
    end
    chk("t5_ended", 32'(test_has_ended), 1);
    chk("t5_no_frame", 32'(seen), 0);

    // Idle timeout on a 3-atom partial buffer.
    do_reset();
    repeat (3) cyc(1'b1, 2'b10, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      cyc(1'b0, 2'b00, 1'b0, 1'b0);
      if (frame_valid) seen = 1'b1;
    end
`ifdef DCT_TIMEOUT_FLUSH_EN
    chk("t6_frame_seen", 32'(seen), 1);
    chk("t6_frame_data", 32'(frame_data), 32'h2A);
    chk("t6_frame_count", 32'(frame_count), 3);
`else
    chk("t6_frame_seen", 32'(seen), 0);
    chk("t6_dct_count", 32'(dct_count), 3);
`endif
    cyc(1'b0, 2'b00, 1'b0, 1'b1);

    // Randomised rounds with varying atom and FIFO rates and a late drain request.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      pv = (r % 3 == 0) ? 3 : int'($urandom_range(20, 95));
      pr = int'($urandom_range(20, 100));
      for (int c = 0; c < 320; c++)
        cyc(int'($urandom_range(0, 99)) < pv, 2'($urandom),
            c > 220 && ($urandom_range(0, 39) == 0), int'($urandom_range(0, 99)) < pr);
      for (int c = 0; c < 40; c++) cyc(1'b0, 2'b00, 1'b1, 1'b1);
      chk("rand_ended", 32'(test_has_ended), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
